// File: rtl/dnn_pkg.sv
// Shared constants, state encoding and weight-lane indices for the DNN input loader.
package dnn_pkg;

  localparam int unsigned N_X         = 4;
  localparam int unsigned N_W         = 24;
  localparam int unsigned X_W         = 7;
  localparam int unsigned W_W         = 5;
  localparam int unsigned FRAME_WORDS = N_X + N_W;
  localparam int unsigned CNT_W       = $clog2(FRAME_WORDS);

  // Prefixed literals so they never collide with the GAP parameter of the top.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  // Lane k of act_w (act_w[W_W*k +: W_W]) for each weight.
  localparam int unsigned K_W04 = 0;
  localparam int unsigned K_W14 = 1;
  localparam int unsigned K_W24 = 2;
  localparam int unsigned K_W34 = 3;
  localparam int unsigned K_W05 = 4;
  localparam int unsigned K_W15 = 5;
  localparam int unsigned K_W25 = 6;
  localparam int unsigned K_W35 = 7;
  localparam int unsigned K_W06 = 8;
  localparam int unsigned K_W16 = 9;
  localparam int unsigned K_W26 = 10;
  localparam int unsigned K_W36 = 11;
  localparam int unsigned K_W07 = 12;
  localparam int unsigned K_W17 = 13;
  localparam int unsigned K_W27 = 14;
  localparam int unsigned K_W37 = 15;
  localparam int unsigned K_W48 = 16;
  localparam int unsigned K_W58 = 17;
  localparam int unsigned K_W68 = 18;
  localparam int unsigned K_W78 = 19;
  localparam int unsigned K_W49 = 20;
  localparam int unsigned K_W59 = 21;
  localparam int unsigned K_W69 = 22;
  localparam int unsigned K_W79 = 23;

endpackage

// File: rtl/dnn_frame_shadow.sv
// Shadow bank: assembles one frame from the byte stream and copies it to the
// active bus when the controller requests it.
module dnn_frame_shadow
  import dnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   copy,
  output logic                   shadow_full,
  output logic [N_X*X_W-1:0]     act_x,
  output logic [N_W*W_W-1:0]     act_w
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  logic [CNT_W-1:0]   wcnt;
  logic [N_X*X_W-1:0] sh_x;
  logic [N_W*W_W-1:0] sh_w;
  logic               take;
  logic               data_unused;

  assign s_ready     = ~shadow_full;
  assign take        = s_valid & s_ready;
  // Bit 7 of every word is never stored.
  assign data_unused = s_data[7];

  // Word counter and full flag; a copy empties the bank, the last word fills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt        <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (copy)
        shadow_full <= 1'b0;
      if (take) begin
        if (wcnt == LAST_WORD) begin
          wcnt        <= '0;
          shadow_full <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

  // Steer each accepted word into its activation or weight lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x <= '0;
      sh_w <= '0;
    end else if (take) begin
      for (int unsigned i = 0; i < N_X; i++)
        if (wcnt == CNT_W'(i))
          sh_x[X_W*i +: X_W] <= s_data[X_W-1:0];
      for (int unsigned k = 0; k < N_W; k++)
        if (wcnt == CNT_W'(N_X + k))
          sh_w[W_W*k +: W_W] <= s_data[W_W-1:0];
    end
  end

  // Active bank changes only on a copy request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x <= '0;
      act_w <= '0;
    end else if (copy) begin
      act_x <= sh_x;
      act_w <= sh_w;
    end
  end

endmodule

// File: rtl/dnn_in_loader.sv
// Double-buffered frame loader in front of dnn_top: issues a frame, waits for
// both output-ready rising edges (or a timeout), then enforces an idle gap.
module dnn_in_loader
  import dnn_pkg::*;
#(
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 64
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [27:0]  act_x,
  output logic [119:0] act_w,
  output logic         dnn_in_ready,
  input  logic         out0_ready,
  input  logic         out1_ready,
  output logic         frame_done,
  output logic         timeout_err,
  output logic         busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

  state_t        state, state_n;
  logic          shadow_full;
  logic          copy, done, tmo;
  logic          prev0, prev1, seen0, seen1, rise0, rise1;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  dnn_frame_shadow u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .copy        (copy),
    .shadow_full (shadow_full),
    .act_x       (act_x),
    .act_w       (act_w)
  );

  assign rise0 = out0_ready & ~prev0;
  assign rise1 = out1_ready & ~prev1;
  assign busy  = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state plus copy/complete/timeout strobes; same-cycle edges count as seen.
  always_comb begin
    state_n = state;
    copy    = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (shadow_full) begin
          copy    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if ((seen0 | rise0) && (seen1 | rise1)) begin
          done    = 1'b1;
          state_n = S_GAP;
        end else if (tcnt == T_LAST) begin
          tmo     = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt == G_LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Edge history tracks the inputs in every state so a held level never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev0 <= 1'b0;
      prev1 <= 1'b0;
    end else begin
      prev0 <= out0_ready;
      prev1 <= out1_ready;
    end
  end

  // Sticky seen flags and timeout counter live only while a frame stays in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen0 <= 1'b0;
      seen1 <= 1'b0;
      tcnt  <= '0;
    end else if (state == S_RUN && state_n == S_RUN) begin
      seen0 <= seen0 | rise0;
      seen1 <= seen1 | rise1;
      tcnt  <= tcnt + 1'b1;
    end else begin
      seen0 <= 1'b0;
      seen1 <= 1'b0;
      tcnt  <= '0;
    end
  end

  // Gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  gcnt <= '0;
    else if (state == S_GAP && state_n == S_GAP) gcnt <= gcnt + 1'b1;
    else                                         gcnt <= '0;
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dnn_in_ready <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (copy)            dnn_in_ready <= 1'b1;
      else if (done | tmo) dnn_in_ready <= 1'b0;
      frame_done  <= done;
      timeout_err <= timeout_err | tmo;
    end
  end

endmodule

// File: tb/tb_dnn_in_loader.sv
`timescale 1ns/1ps
module tb_dnn_in_loader;
  import dnn_pkg::*;

  localparam int GAP_C = 2;
  localparam int TMO_C = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [27:0]  act_x;
  logic [119:0] act_w;
  logic         dnn_in_ready;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic         frame_done;
  logic         timeout_err;
  logic         busy;

  dnn_in_loader #(.GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .act_x        (act_x),
    .act_w        (act_w),
    .dnn_in_ready (dnn_in_ready),
    .out0_ready   (out0_ready),
    .out1_ready   (out1_ready),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0]  x;
    logic [119:0] w;
  } frame_t;

  frame_t      sb[$];
  logic [7:0]  fw [56];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int unsigned k_order [N_W] = '{K_W04, K_W14, K_W24, K_W34, K_W05, K_W15, K_W25, K_W35,
                                 K_W06, K_W16, K_W26, K_W36, K_W07, K_W17, K_W27, K_W37,
                                 K_W48, K_W58, K_W68, K_W78, K_W49, K_W59, K_W69, K_W79};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && frame_done) done_cnt++;

  // Reference model: expected active bank for the frame stored at fw[base..base+27].
  task automatic push_exp(input int base);
    frame_t f;
    f.x = '0;
    f.w = '0;
    for (int i = 0; i < N_X; i++) f.x[X_W*i +: X_W] = fw[base+i][X_W-1:0];
    for (int j = 0; j < N_W; j++) f.w[W_W*k_order[j] +: W_W] = fw[base+N_X+j][W_W-1:0];
    sb.push_back(f);
  endtask

  task automatic send_word(input logic [7:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL s_ready_wait: s_ready=%b, required 1 within 400 cycles", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic stream(input int base, input int n);
    for (int j = 0; j < n; j++) send_word(fw[base+j]);
    s_valid = 1'b0;
  endtask

  task automatic fill_random(input int base);
    for (int j = 0; j < FRAME_WORDS; j++) fw[base+j] = 8'($urandom);
  endtask

  // Wait for an issued frame and pop/compare its expected contents.
  task automatic wait_issue(output int t);
    int n = 0;
    frame_t f;
    while (!dnn_in_ready && n < 400) begin @(negedge clk); n++; end
    t = cyc;
    checks++;
    if (!dnn_in_ready) begin
      errors++;
      $display("FAIL issue_wait: dnn_in_ready=%b, required 1 within 400 cycles", dnn_in_ready);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL issue_unexpected: scoreboard size %0d, required >0", sb.size());
    end else begin
      f = sb.pop_front();
      checks++;
      if (act_x !== f.x) begin
        errors++;
        $display("FAIL act_x: got %h, required %h", act_x, f.x);
      end
      checks++;
      if (act_w !== f.w) begin
        errors++;
        $display("FAIL act_w: got %h, required %h", act_w, f.w);
      end
    end
  endtask

  // Modelled core: both output-ready flags rise together after lat cycles.
  task automatic complete_frame(input int lat, output int t_done);
    repeat (lat) @(negedge clk);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(negedge clk);
    t_done = cyc;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: frame_done=%b, required 1", frame_done);
    end
    checks++;
    if (dnn_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: dnn_in_ready=%b, required 0", dnn_in_ready);
    end
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b, required 1", s_ready); end
    checks++;
    if ({dnn_in_ready, frame_done, timeout_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags: got %b, required 0000", {dnn_in_ready, frame_done, timeout_err, busy});
    end
    checks++;
    if (act_x !== 28'h0 || act_w !== 120'h0) begin
      errors++;
      $display("FAIL rst_act: got %h/%h, required 0/0", act_x, act_w);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int t, td, d0;
    d0 = done_cnt;
    fill_random(0);
    fw[0] = 8'h84; fw[1] = 8'h02; fw[2] = 8'h04; fw[3] = 8'h81;
    fw[4] = 8'hE3; fw[5] = 8'h02; fw[6] = 8'h0D; fw[7] = 8'h1A;
    push_exp(0);
    stream(0, FRAME_WORDS);
    checks++;
    if (dnn_in_ready !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_last_word: ready/s_ready %b%b, required 00", dnn_in_ready, s_ready);
    end
    @(negedge clk);
    checks++;
    if (dnn_in_ready !== 1'b1) begin errors++; $display("FAIL single_issue_latency: got %b, required 1", dnn_in_ready); end
    checks++;
    if (act_x !== 28'h0210104) begin errors++; $display("FAIL single_act_x: got %h, required 0210104", act_x); end
    checks++;
    if (act_w[4:0] !== 5'h03 || act_w[19:15] !== 5'h1A) begin
      errors++;
      $display("FAIL single_w04_w34: got %h/%h, required 03/1a", act_w[4:0], act_w[19:15]);
    end
    wait_issue(t);
    complete_frame(20, td);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || dnn_in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap1: done/ready/busy %b%b%b, required 001", frame_done, dnn_in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (dnn_in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_gap_end: ready/busy %b%b, required 00", dnn_in_ready, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, td, td2;
    fill_random(0);
    fill_random(28);
    push_exp(0);
    push_exp(28);
    fork
      begin
        stream(0, FRAME_WORDS);
        s_valid = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready_word28: got %b, required 0", s_ready); end
        stream(28, FRAME_WORDS);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_held: s_ready/busy %b%b, required 01", s_ready, busy);
        end
      end
      begin
        wait_issue(t1);
        complete_frame(40, td);
        wait_issue(t2);
        checks++;
        if (t2 - td !== GAP_C + 1) begin
          errors++;
          $display("FAIL b2b_reissue_delay: got %0d cycles, required %0d", t2 - td, GAP_C + 1);
        end
        complete_frame(20, td2);
      end
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_split_edges(input int r0, input int r1);
    int t, d0;
    bit early;
    fill_random(0);
    push_exp(0);
    stream(0, FRAME_WORDS);
    wait_issue(t);
    d0 = done_cnt;
    early = 1'b0;
    for (int c = 0; c <= r1; c++) begin
      if (c == r0) out0_ready = 1'b1;
      if (c == r1) out1_ready = 1'b1;
      if (frame_done !== 1'b0 || dnn_in_ready !== 1'b1) early = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (early) begin errors++; $display("FAIL split_early_%0d_%0d: early completion 1, required 0", r0, r1); end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL split_done_%0d_%0d: got %b, required 1", r0, r1, frame_done); end
    repeat (4) @(negedge clk);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL split_count_%0d_%0d: got %0d, required 1", r0, r1, done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int t, d0, hi;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    fill_random(0);
    push_exp(0);
    stream(0, FRAME_WORDS);
    wait_issue(t);
    d0 = done_cnt;
    hi = 0;
    while (dnn_in_ready && hi < 200) begin hi++; @(negedge clk); end
    checks++;
    if (hi !== TMO_C) begin errors++; $display("FAIL timeout_run_cycles: got %0d, required %0d", hi, TMO_C); end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b, required 1", timeout_err); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL timeout_no_done: got %0d pulses, required 0", done_cnt - d0); end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err/busy %b%b, required 10", timeout_err, busy);
    end
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic test_width_mask();
    int t, td;
    for (int j = 0; j < FRAME_WORDS; j++) fw[j] = 8'hFF;
    push_exp(0);
    stream(0, FRAME_WORDS);
    wait_issue(t);
    checks++;
    if (act_x !== 28'hFFFFFFF || act_w !== {120{1'b1}}) begin
      errors++;
      $display("FAIL mask_all_ones: got %h/%h, required all ones", act_x, act_w);
    end
    complete_frame(10, td);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midload();
    int t, td;
    fill_random(0);
    stream(0, 10);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || {dnn_in_ready, frame_done, timeout_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_flags: s_ready/flags %b/%b, required 1/0000", s_ready,
               {dnn_in_ready, frame_done, timeout_err, busy});
    end
    checks++;
    if (act_x !== 28'h0 || act_w !== 120'h0) begin
      errors++;
      $display("FAIL midrst_act: got %h/%h, required 0/0", act_x, act_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(0);
    push_exp(0);
    stream(0, FRAME_WORDS);
    checks++;
    if (dnn_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_no_residue_early: got %b, required 0", dnn_in_ready); end
    wait_issue(t);
    complete_frame(15, td);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_split_edges(5, 12);
    test_split_edges(3, 3);
    test_timeout();
    test_width_mask();
    test_reset_midload();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
